boot_loaded_memory: RTL
=======================

# boot_loaded_memory

Memory responder for the MIPS pipeline core. It serves the core's instruction-fetch port (read only) and data port (read/write) from one shared word array, and owns program loading. After reset it holds the core in reset and streams program words in through a valid/ready load port, then releases the core. It sits beside the pipeline top: `inst_adr` → `inst`, and `data_adr` / `data_out` / `mem_read` / `mem_write` → `data_in`.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- IDX_W, log2(DEPTH_WORDS): word-index width, derived.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- inst_adr  in  32  byte address of the instruction fetch.
- inst  out  32  fetched instruction word.
- data_adr  in  32  byte address of the data access.
- data_wdata  in  32  store data (the core's `data_out`).
- data_rdata  out  32  load data (the core's `data_in`).
- mem_read  in  1  data read strobe.
- mem_write  in  1  data write strobe.
- load_valid  in  1  the load word is valid.
- load_data  in  32  program word.
- load_last  in  1  marks the final program word.
- load_ready  out  1  high while in LOAD.
- boot_skip  in  1  leave LOAD without loading; the array keeps its contents.
- core_rst  out  1  active-high reset to the core; high until RUN.
- err_misaligned  out  1  sticky: a data access had `data_adr[1:0] != 0`.
- err_range  out  1  sticky: a data access had word index ≥ DEPTH_WORDS.

## Operation
- FSM states: LOAD, RUN. Reset → LOAD.
  - LOAD → RUN on an accepted word with `load_last` = 1.
  - LOAD → RUN on acceptance of the word at index DEPTH_WORDS-1.
  - LOAD → RUN on `boot_skip` = 1.
  - RUN is left only by reset.
- Load pointer `load_ptr` (IDX_W bits): reset 0.
  - A word is accepted when `load_valid & load_ready`.
  - An accepted word is written to `mem[load_ptr]` and `load_ptr` increments.
  - There is no wrap: the last index forces RUN.
- Instruction port: `inst = mem[inst_adr[IDX_W+1:2]]`. Combinational and active in both states. Upper and low address bits are ignored.
- Data port (RUN only):
  - Word index `data_adr[IDX_W+1:2]`.
  - Access is valid when `data_adr[1:0] == 0` and `data_adr[31:IDX_W+2] == 0`.
  - Valid read: `data_rdata = mem[idx]`, combinational. Invalid access, or `mem_read` = 0: `data_rdata` = 0.
  - Valid `mem_write`: `mem[idx] <= data_wdata` at the edge. Invalid writes are dropped.
  - `mem_read` and `mem_write` both high: the write is performed and `data_rdata` shows the pre-edge content.
- Error flags are set on any strobed invalid access in RUN. They are cleared only by reset.
- During LOAD the data port is ignored: `data_rdata` = 0, no writes, no error flags.
- The array is not cleared by reset.

## Timing
- Reset values: state LOAD, `load_ptr` 0, `core_rst` 1, `load_ready` 1, both error flags 0. `inst` and `data_rdata` are combinational.
- `load_ready` is decoded from state, so it is high in the first cycle after reset release.
- `core_rst` is registered and falls on the same edge that enters RUN.
- Reads: zero-cycle latency. Writes are visible to both read ports from the cycle after the edge.
- Same-cycle fetch of an address being written returns the old word.
- `boot_skip` takes priority over a simultaneous load handshake; that word is not written.
- Reset asserted mid-load: returns to LOAD, `load_ptr` = 0; already-written words remain.

## Structure
- Package `mem_pkg`:
  - state enum `{LOAD, RUN}`
  - `WORD_W` = 32
  - address-decode helper constants (byte-offset width 2)
- Sub-module `mem_array`:
  - DEPTH_WORDS × 32 storage
  - two asynchronous read ports and one synchronous write port
- The top level holds the FSM, the load pointer, the write-source mux (loader vs data port) and the error logic.

## Test plan
- Reset, then stream words 0x11, 0x22, 0x33 with `load_last` on the third → `core_rst` falls on the third accept edge. After that, `inst_adr` = 0/4/8 returns 0x11/0x22/0x33.
- In RUN, store 0xDEADBEEF with `data_adr` = 0x10 → `data_rdata` = 0xDEADBEEF the next cycle with `mem_read` = 1. `inst` at 0x10 reads the same word.
- `mem_write` with `data_adr` = 0x13 → no write, `err_misaligned` = 1 and stays 1. An access at 0x1000 (DEPTH 1024) → `err_range` = 1 and `data_rdata` = 0.
- Hold `load_valid` high with `load_last` = 0 for 1024 words → RUN after word 1023, and `load_ready` = 0 after that.
- Assert `boot_skip` with `load_valid` = 1 on the same cycle → RUN, that word is not written, and `core_rst` = 0 next cycle.
- Pull `rst` low mid-load after 5 words, then reload 2 words with `last` → words 0–1 are new, words 2–4 keep their old values.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the boot-loaded memory responder.
package mem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage with two asynchronous read ports and one synchronous write port.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_a_i,
    output logic [WORD_W-1:0] rdata_a_o,
    input  logic [IDX_W-1:0]  raddr_b_i,
    output logic [WORD_W-1:0] rdata_b_o
);

    // Contents survive reset, so the array has no reset path at all.
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/boot_loaded_memory.sv
// Instruction/data memory for the MIPS core; streams the program in after reset
// and holds the core in reset until loading finishes.
module boot_loaded_memory
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] inst_adr,
    output logic [WORD_W-1:0] inst,
    input  logic [WORD_W-1:0] data_adr,
    input  logic [WORD_W-1:0] data_wdata,
    output logic [WORD_W-1:0] data_rdata,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              boot_skip,
    output logic              core_rst,
    output logic              err_misaligned,
    output logic              err_range
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  load_ptr_q, load_ptr_d;
    logic              core_rst_q, core_rst_d;
    logic              err_mis_q, err_mis_d;
    logic              err_rng_q, err_rng_d;

    logic              in_run;
    logic              load_accept;
    logic [IDX_W-1:0]  data_idx;
    logic              data_aligned;
    logic              data_in_range;
    logic              data_strobe;
    logic              data_wr_ok;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata_data;

    assign in_run      = (state_q == RUN);
    assign load_ready  = (state_q == LOAD);
    // boot_skip wins over a simultaneous handshake: that word is dropped.
    assign load_accept = load_ready & load_valid & ~boot_skip;

    assign data_idx      = data_adr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
    assign data_aligned  = (data_adr[BYTE_OFF_W-1:0] == '0);
    assign data_in_range = (data_adr[WORD_W-1:IDX_W+BYTE_OFF_W] == '0);
    assign data_strobe   = in_run & (mem_read | mem_write);
    assign data_wr_ok    = in_run & mem_write & data_aligned & data_in_range;

    // Loader owns the write port in LOAD, the core's data port owns it in RUN.
    assign arr_we    = load_accept | data_wr_ok;
    assign arr_waddr = in_run ? data_idx : load_ptr_q;
    assign arr_wdata = in_run ? data_wdata : load_data;

    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        err_mis_d  = err_mis_q;
        err_rng_d  = err_rng_q;
        if (state_q == LOAD) begin
            if (boot_skip) begin
                state_d = RUN;
            end else if (load_accept) begin
                load_ptr_d = load_ptr_q + IDX_W'(1);
                if (load_last || (load_ptr_q == LAST_IDX)) begin
                    state_d = RUN;
                end
            end
        end else begin
            if (data_strobe && !data_aligned) begin
                err_mis_d = 1'b1;
            end
            if (data_strobe && !data_in_range) begin
                err_rng_d = 1'b1;
            end
        end
        core_rst_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOAD;
            load_ptr_q <= '0;
            core_rst_q <= 1'b1;
            err_mis_q  <= 1'b0;
            err_rng_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            core_rst_q <= core_rst_d;
            err_mis_q  <= err_mis_d;
            err_rng_q  <= err_rng_d;
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk       (clk),
        .we_i      (arr_we),
        .waddr_i   (arr_waddr),
        .wdata_i   (arr_wdata),
        .raddr_a_i (inst_adr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]),
        .rdata_a_o (inst),
        .raddr_b_i (data_idx),
        .rdata_b_o (arr_rdata_data)
    );

    assign data_rdata = (in_run & mem_read & data_aligned & data_in_range)
                        ? arr_rdata_data : '0;

    assign core_rst       = core_rst_q;
    assign err_misaligned = err_mis_q;
    assign err_range      = err_rng_q;

    // Fetches ignore the byte offset and any address bits above the array.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_adr[WORD_W-1:IDX_W+BYTE_OFF_W],
                                inst_adr[BYTE_OFF_W-1:0]};

endmodule
